// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared timing sets and helpers for the VGA raster generator
package vga_timing_pkg;

    typedef struct packed {
        int vis;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    // 800x600@72 from a 50 MHz clock with pix_en tied high
    localparam axis_timing_t SVGA72_H = '{vis: 800, fp: 56, sync: 120, bp: 64};
    localparam axis_timing_t SVGA72_V = '{vis: 600, fp: 37, sync: 6,   bp: 23};

    // 640x480@60 from a 50 MHz clock with pix_en high one clock in two
    localparam axis_timing_t VGA60_H = '{vis: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t VGA60_V = '{vis: 480, fp: 10, sync: 2,  bp: 33};
    localparam int VGA60_PIX_DIV = 2;

    function automatic int seg_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with registered sync decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS  = 800,
    parameter int FP   = 56,
    parameter int SYNC = 120,
    parameter int BP   = 64,
    parameter bit POL  = 1'b0,
    parameter int W    = 11
) (
    input  logic         clk_50m,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         sync,
    output logic         active,
    output logic         wrap
);

    localparam int TOTAL = seg_total(VIS, FP, SYNC, BP);
    localparam logic [31:0] VIS_32     = 32'(VIS);
    localparam logic [31:0] SYNC_LO_32 = 32'(VIS + FP);
    localparam logic [31:0] SYNC_HI_32 = 32'(VIS + FP + SYNC);
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

    if (VIS < 1 || FP < 1 || SYNC < 1 || BP < 1 || longint'(TOTAL) > (64'd1 << W)) begin : g_bad_params
        $error("vga_axis_counter: segment below 1 or total does not fit counter width");
    end

    logic [W-1:0] count_next;
    logic [31:0]  next_32;
    logic         sync_next;

    assign wrap = (count == LAST);

    always_comb begin
        count_next = count;
        if (advance) begin
            count_next = wrap ? '0 : count + W'(1);
        end
    end

    // active describes the value being loaded on this edge, so the top can register it
    // alongside count without adding a cycle of skew.
    assign next_32   = 32'(count_next);
    assign active    = (next_32 < VIS_32);
    assign sync_next = (next_32 >= SYNC_LO_32) && (next_32 < SYNC_HI_32);

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            count <= LAST;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            sync  <= sync_next ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel enable and aligned strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_VIS  = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int X_W    = $clog2(seg_total(H_VIS, H_FP, H_SYNC, H_BP)),
    parameter int Y_W    = $clog2(seg_total(V_VIS, V_FP, V_SYNC, V_BP))
) (
    input  logic           clk_50m,
    input  logic           rst,
    input  logic           pix_en,
    output logic [X_W-1:0] vector_x,
    output logic [Y_W-1:0] vector_y,
    output logic           VGA_HS,
    output logic           VGA_VS,
    output logic           video_on,
    output logic           line_start,
    output logic           frame_start
);

    logic h_wrap, v_wrap;
    logic h_active, v_active;
    logic v_advance;

    assign v_advance = pix_en & h_wrap;

    vga_axis_counter #(
        .VIS (H_VIS),
        .FP  (H_FP),
        .SYNC(H_SYNC),
        .BP  (H_BP),
        .POL (HS_POL),
        .W   (X_W)
    ) u_h_axis (
        .clk_50m(clk_50m),
        .rst    (rst),
        .advance(pix_en),
        .count  (vector_x),
        .sync   (VGA_HS),
        .active (h_active),
        .wrap   (h_wrap)
    );

    // VS only moves on an x wrap, keeping its edges aligned to line start
    vga_axis_counter #(
        .VIS (V_VIS),
        .FP  (V_FP),
        .SYNC(V_SYNC),
        .BP  (V_BP),
        .POL (VS_POL),
        .W   (Y_W)
    ) u_v_axis (
        .clk_50m(clk_50m),
        .rst    (rst),
        .advance(v_advance),
        .count  (vector_y),
        .sync   (VGA_VS),
        .active (v_active),
        .wrap   (v_wrap)
    );

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_on    <= h_active & v_active;
            line_start  <= v_advance;
            frame_start <= v_advance & v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen, default and tiny timings
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        int n;
        bit ls;
        bit fs;
        int ph;
    } exp_t;

    typedef struct {
        int x, y;
        bit hs, vs, vo;
    } view_t;

    localparam tim_t TA = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b0, 1'b0};
    localparam tim_t TB = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

    logic clk_50m = 1'b0;
    logic rst;
    logic pix_en;

    logic [10:0] ax;
    logic [9:0]  ay;
    logic a_hs, a_vs, a_vo, a_ls, a_fs;
    logic [2:0] bx;
    logic [2:0] by;
    logic b_hs, b_vs, b_vo, b_ls, b_fs;

    int tests = 0;
    int failed = 0;
    exp_t qa[$];
    exp_t qb[$];
    int na, nb;

    always #10 clk_50m = ~clk_50m;

    vga_timing_gen u_dut_a (
        .clk_50m(clk_50m), .rst(rst), .pix_en(pix_en),
        .vector_x(ax), .vector_y(ay), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .video_on(a_vo), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_b (
        .clk_50m(clk_50m), .rst(rst), .pix_en(pix_en),
        .vector_x(bx), .vector_y(by), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .video_on(b_vo), .line_start(b_ls), .frame_start(b_fs)
    );

    function automatic int h_tot(input tim_t t);
        return t.hv + t.hf + t.hs + t.hb;
    endfunction

    function automatic int f_tot(input tim_t t);
        return h_tot(t) * (t.vv + t.vf + t.vs + t.vb);
    endfunction

    // Raster position n counts pixels from the top-left of the frame
    function automatic view_t view(input tim_t t, input int n);
        view_t v;
        v.x  = n % h_tot(t);
        v.y  = n / h_tot(t);
        v.hs = (v.x >= t.hv + t.hf && v.x < t.hv + t.hf + t.hs) ? t.hp : ~t.hp;
        v.vs = (v.y >= t.vv + t.vf && v.y < t.vv + t.vf + t.vs) ? t.vp : ~t.vp;
        v.vo = (v.x < t.hv) && (v.y < t.vv);
        return v;
    endfunction

    function automatic exp_t step(input tim_t t, inout int n, input bit r, input bit pe, input int ph);
        exp_t e;
        e.ls = 1'b0;
        e.fs = 1'b0;
        if (r) begin
            n = f_tot(t) - 1;
        end else if (pe) begin
            n = (n + 1) % f_tot(t);
            e.ls = (n % h_tot(t)) == 0;
            e.fs = (n == 0);
        end
        e.n  = n;
        e.ph = ph;
        return e;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit r, input bit pe, input int ph);
        @(negedge clk_50m);
        rst    = r;
        pix_en = pe;
        qa.push_back(step(TA, na, r, pe, ph));
        qb.push_back(step(TB, nb, r, pe, ph));
    endtask

    // Monitor: one popped expectation per DUT per clock, plus period/width checks
    initial begin
        exp_t e;
        view_t v;
        int cyc = 0;
        int a_last_ls = -1, a_last_ph = -1;
        int b_last_fs = -1, b_last_ph = -1;
        int hs_run = 0;
        forever begin
            @(posedge clk_50m);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                v = view(TA, e.n);
                cmp("a_x",  int'(ax), v.x);
                cmp("a_y",  int'(ay), v.y);
                cmp("a_hs", int'(a_hs), int'(v.hs));
                cmp("a_vs", int'(a_vs), int'(v.vs));
                cmp("a_video_on", int'(a_vo), int'(v.vo));
                cmp("a_line_start", int'(a_ls), int'(e.ls));
                cmp("a_frame_start", int'(a_fs), int'(e.fs));
                if (a_ls === 1'b1 && (e.ph == 2 || e.ph == 3)) begin
                    if (a_last_ls >= 0 && a_last_ph == e.ph)
                        cmp("a_line_period", cyc - a_last_ls, (e.ph == 2) ? 1040 : 2080);
                    a_last_ls = cyc;
                    a_last_ph = e.ph;
                end
                if (e.ph == 2 && a_hs === 1'b0) begin
                    hs_run++;
                end else begin
                    if (hs_run > 0) cmp("a_hs_width", hs_run, 120);
                    hs_run = 0;
                end
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                v = view(TB, e.n);
                cmp("b_x",  int'(bx), v.x);
                cmp("b_y",  int'(by), v.y);
                cmp("b_hs", int'(b_hs), int'(v.hs));
                cmp("b_vs", int'(b_vs), int'(v.vs));
                cmp("b_video_on", int'(b_vo), int'(v.vo));
                cmp("b_line_start", int'(b_ls), int'(e.ls));
                cmp("b_frame_start", int'(b_fs), int'(e.fs));
                if (b_fs === 1'b1 && (e.ph == 2 || e.ph == 3)) begin
                    if (b_last_fs >= 0 && b_last_ph == e.ph)
                        cmp("b_frame_period", cyc - b_last_fs, (e.ph == 2) ? 48 : 96);
                    b_last_fs = cyc;
                    b_last_ph = e.ph;
                end
            end
            cyc++;
        end
    end

    initial begin
        rst    = 1'b1;
        pix_en = 1'b0;
        na = 0;
        nb = 0;
        repeat (3) drive(1'b1, 1'($urandom_range(0, 1)), 1);
        repeat (2100) drive(1'b0, 1'b1, 2);
        for (int i = 0; i < 4400; i++) drive(1'b0, ((i % 2) == 0), 3);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                repeat ($urandom_range(1, 3)) drive(1'b1, 1'($urandom_range(0, 1)), 4);
            end else begin
                drive(1'b0, ($urandom_range(0, 3) != 0), 4);
            end
        end
        repeat (4) @(posedge clk_50m);
        #2;
        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: walks a pixel/line counter pair across a configurable frame and emits horizontal/vertical sync, an active-video flag and line/frame start strobes. All outputs are registered and mutually aligned to the reported coordinate. A pixel-clock enable lets one system clock serve several pixel rates. It sits between the system clock and the pixel renderers/colour mux, which consume the coordinates and `video_on`.

## Interface
- `H_VIS`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, in pixels
- `H_SYNC`, 120: HS pulse width, in pixels
- `H_BP`, 64: horizontal back porch, in pixels
- `V_VIS`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: VS pulse width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `HS_POL`, 0: HS active level (0 = active-low)
- `VS_POL`, 0: VS active level
- `X_W`, `$clog2(H_VIS+H_FP+H_SYNC+H_BP)`: width of `vector_x`
- `Y_W`, `$clog2(V_VIS+V_FP+V_SYNC+V_BP)`: width of `vector_y`
- `clk_50m` in 1: system clock; all logic is on the rising edge
- `rst` in 1: synchronous reset, active-high
- `pix_en` in 1: pixel advance enable; the raster advances one pixel per clk with `pix_en`=1
- `vector_x` out X_W: current pixel column, 0..H_TOTAL-1
- `vector_y` out Y_W: current line, 0..V_TOTAL-1
- `VGA_HS` out 1: horizontal sync
- `VGA_VS` out 1: vertical sync
- `video_on` out 1: 1 when `vector_x` < H_VIS and `vector_y` < V_VIS
- `line_start` out 1: one-clk pulse when `vector_x` becomes 0
- `frame_start` out 1: one-clk pulse when (x,y) becomes (0,0)

## Operation
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V parameters.
- Elaboration fails if any segment is less than 1, or if either total exceeds 2^width.
- Reset values:
  - `vector_x` = H_TOTAL-1, `vector_y` = V_TOTAL-1
  - `VGA_HS` = ~HS_POL, `VGA_VS` = ~VS_POL
  - `video_on`, `line_start` and `frame_start` = 0
  - Consequence: the first enabled clk after reset presents (0,0) with `frame_start` = 1.
- On a clk with `pix_en` = 1:
  - x increments, wrapping H_TOTAL-1 to 0.
  - On an x wrap, y increments, wrapping V_TOTAL-1 to 0.
  - With `pix_en` = 0, all coordinate and sync outputs hold.
- HS is active when H_VIS+H_FP ≤ x < H_VIS+H_FP+H_SYNC.
- VS is active when V_VIS+V_FP ≤ y < V_VIS+V_FP+V_SYNC. VS changes only at an x wrap, i.e. aligned to line start.
- Sync, `video_on` and strobes are decoded from the next-count value and registered in the same clk as the counters. They therefore describe exactly the (x,y) presented, with zero skew between them.
- `line_start` and `frame_start` are high for exactly one clk, the clk in which the new coordinate first appears. They clear on the next clk even if `pix_en` stays low.
- `rst` asserted mid-frame: counters reload H_TOTAL-1/V_TOTAL-1 on that edge and syncs go inactive immediately. `rst` has priority over `pix_en`.

## Timing
- Latency: zero clks between the coordinate and its decoded outputs. All outputs are direct flop outputs with no combinational path from `pix_en`.
- Defaults (800x600@72, `pix_en` tied 1, 50 MHz):
  - Line = 1040 clk; HS active for x 856..975 (120 clk).
  - Frame = 666 lines = 692640 clk; VS active for y 637..642.
- With `pix_en` at a 1-in-N duty, every period scales by N. Strobe width stays 1 clk.

## Structure
- Package `vga_timing_pkg`:
  - Default parameter sets: 800x600@72 on 50 MHz, and 640x480@60 on 25 MHz (via `pix_en` 1-of-2).
  - A helper function computing the total from the four segments.
- Sub-module `vga_axis_counter` (parameters VIS/FP/SYNC/BP/POL/W), instantiated twice:
  - Ports: `advance` in; `count`, `sync`, `active`, `wrap` out.
  - Horizontal instance: `advance` = `pix_en`.
  - Vertical instance: `advance` = `pix_en` & horizontal `wrap`.
- Top level combines `active`, derives the strobes and owns the reset values.

## Test plan
- Reset with defaults: hold `rst` 3 clk -> outputs (1039,665), HS=1, VS=1, `video_on`=0. First clk after release -> (0,0), `frame_start`=1, `line_start`=1, `video_on`=1.
- Free run one full frame -> `line_start` count 666, `frame_start` once per 692640 clk, `video_on` high for 480000 clk, HS low for 120 clk starting at x=856.
- `pix_en` toggling 1,0 -> line = 2080 clk. Each strobe is 1 clk wide. Coordinates and syncs hold during `pix_en`=0 clks.
- Reset asserted at (500,300) with `pix_en`=1 -> next clk (1039,665) with syncs inactive; clk after release -> (0,0) with `frame_start`.
- Small params H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1 -> line = 8 clk; HS high at x=5,6; VS high on y=4 only; frame = 48 clk.
- Wrap corner: at (H_TOTAL-1, V_TOTAL-1) with `pix_en` -> (0,0) in one clk, VS and HS both updating in the same clk, no glitch cycle.
